// File: rtl/div_16bit.sv
// Iterative shift-and-subtract integer divider, one quotient bit per clock.
// Signed operands are divided as magnitudes and the signs restored in a final fix-up cycle.
module div_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic             Zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = WIDTH + 2;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             divzero_q, divzero_d;
  logic             zero_q, zero_d;

  logic [WIDTH:0]   r_sh;
  logic [SW-1:0]    diff;
  logic             carry;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;

  always_comb begin
    // Subtract via R + ~{0,D} + 1; the carry out of bit WIDTH means no borrow.
    r_sh  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff  = {1'b0, r_sh} + {1'b0, ~{1'b0, dv_q}} + SW'(1);
    carry = diff[WIDTH+1];

    a_abs = (Signed && A[WIDTH-1]) ? (~A + ONE) : A;
    b_abs = (Signed && B[WIDTH-1]) ? (~B + ONE) : B;
    q_fix = neg_q_q ? (~q_q + ONE) : q_q;
    r_fix = neg_r_q ? (~r_q[WIDTH-1:0] + ONE) : r_q[WIDTH-1:0];

    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    dv_d      = dv_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divzero_d = divzero_q;
    zero_d    = zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (B == '0) begin
            // Divide by zero skips RUN; Q carries the raw dividend to FIX.
            state_d = S_FIX;
            dz_d    = 1'b1;
            q_d     = A;
          end else begin
            state_d = S_RUN;
            dz_d    = 1'b0;
            busy_d  = 1'b1;
            neg_q_d = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r_d = Signed & A[WIDTH-1];
            q_d     = a_abs;
            dv_d    = b_abs;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      S_RUN: begin
        r_d   = carry ? diff[WIDTH:0] : r_sh;
        q_d   = {q_q[WIDTH-2:0], carry};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (dz_q) begin
          quot_d    = '1;
          rem_d     = q_q;
          divzero_d = 1'b1;
          zero_d    = 1'b0;
        end else begin
          quot_d    = q_fix;
          rem_d     = r_fix;
          divzero_d = 1'b0;
          zero_d    = (q_fix == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dv_q      <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      divzero_q <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      dv_q      <= dv_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divzero_q <= divzero_d;
      zero_q    <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign DivZero   = divzero_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_div_16bit.sv
// Randomized scoreboard bench for div_16bit: a driver queues expected results,
// a monitor pops and compares them on every done pulse.
module tb_div_16bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        Signed;
  logic [15:0] A, B;
  logic        busy, done;
  logic [15:0] Quotient, Remainder;
  logic        DivZero, Zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        z;
    int          due;
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t sb[$];

  div_16bit #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .Signed(Signed), .A(A), .B(B),
    .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder),
    .DivZero(DivZero), .Zero(Zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Reference: plain integer division; int arithmetic truncates toward zero.
  function automatic exp_t model(logic s, logic [15:0] a, logic [15:0] b);
    exp_t e;
    int ai, bi, qi, ri;
    e.s = s; e.a = a; e.b = b;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
    end else begin
      ai = s ? int'($signed(a)) : int'({16'd0, a});
      bi = s ? int'($signed(b)) : int'({16'd0, b});
      qi = ai / bi;
      ri = ai % bi;
      e.q = qi[15:0]; e.r = ri[15:0]; e.dz = 1'b0;
    end
    e.z = (e.q == 16'd0);
    e.due = 0;
    return e;
  endfunction

  // Called at a negedge; drives start for one rising edge.
  task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e = model(s, a, b);
    e.due = cyc + 1 + ((b == 16'd0) ? 1 : 17);
    sb.push_back(e);
    Signed = s; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, {31'd0, (b != 16'd0)});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient",  {16'd0, Quotient},  {16'd0, e.q});
          chk("remainder", {16'd0, Remainder}, {16'd0, e.r});
          chk("divzero",   {31'd0, DivZero},   {31'd0, e.dz});
          chk("zero",      {31'd0, Zero},      {31'd0, e.z});
          chk("latency",   cyc,                e.due);
          $display("op s=%0d a=%04h b=%04h -> q=%04h r=%04h dz=%0d z=%0d", e.s, e.a, e.b,
                   Quotient, Remainder, DivZero, Zero);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    reset = 1'b1; start = 1'b0; Signed = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", {16'd0, Quotient}, 32'd0);
    chk("rst_rem",  {16'd0, Remainder}, 32'd0);
    chk("rst_dz",   {31'd0, DivZero}, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases, issued back-to-back in the done cycle.
    issue(1'b0, 16'd100, 16'd7);     wait_done();
    issue(1'b1, 16'hFFF9, 16'd2);    wait_done();
    issue(1'b0, 16'h1234, 16'd0);    wait_done();
    issue(1'b1, 16'h8000, 16'hFFFF); wait_done();
    issue(1'b0, 16'hFFFF, 16'd1);    wait_done();
    issue(1'b0, 16'd3, 16'd9);       wait_done();
    issue(1'b1, 16'h0007, 16'hFFFE); wait_done();
    issue(1'b1, 16'h8000, 16'd0);    wait_done();

    // Start while busy: the extra start pulse must be ignored.
    issue(1'b0, 16'd1000, 16'd3);
    repeat (4) @(negedge clk);
    Signed = 1'b1; A = 16'h5555; B = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (25) @(negedge clk);
    chk("busy_idle_after_ignored_start", {31'd0, busy}, 32'd0);

    // Reset mid-operation: aborted op produces no done pulse.
    issue(1'b0, 16'd100, 16'd7);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quot", {16'd0, Quotient}, 32'd0);
    chk("midrst_rem",  {16'd0, Remainder}, 32'd0);
    chk("midrst_zero", {31'd0, Zero}, 32'd1);
    chk("midrst_dz",   {31'd0, DivZero}, 32'd0);
    reset = 1'b0;
    sb.delete();
    repeat (20) @(negedge clk);
    issue(1'b0, 16'd100, 16'd7);
    wait_done();

    // Randomized traffic, including small and zero divisors.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      issue(rs, ra, rb);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
